// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family: direction/mode encodings
// and the prescaler default for 50 MHz boards.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam int unsigned DEF_DIV_BITS = 24;

endpackage : counter_pkg

// File: rtl/synch_updown_counter_if.sv
// Control/status bundle of synch_updown_counter; master drives controls,
// slave (the counter) returns count, tick and tc.
interface synch_updown_counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             dir;
    logic             sat;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             tc;

    modport master (
        output en, dir, sat, load, load_val,
        input  count, tick, tc
    );

    modport slave (
        input  en, dir, sat, load, load_val,
        output count, tick, tc
    );
endinterface : synch_updown_counter_if

// File: rtl/synch_updown_counter_tick_gen.sv
// Clock-enable prescaler: one tick every 2^DIV_BITS enabled clocks,
// freezing while en is low and restarting on clr.
module tick_gen #(
    parameter int unsigned DIV_BITS = counter_pkg::DEF_DIV_BITS
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    generate
        if (DIV_BITS == 0) begin : g_nodiv
            // No divider register: every enabled cycle is a step.
            logic unused_presc;
            assign unused_presc = clk ^ clr;
            assign tick         = en & reset;
        end else begin : g_div
            localparam logic [DIV_BITS-1:0] PRESC_MAX = '1;

            logic [DIV_BITS-1:0] presc_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    presc_q <= '0;
                end else if (clr) begin
                    presc_q <= '0;
                end else if (en) begin
                    presc_q <= presc_q + DIV_BITS'(1);
                end
            end

            assign tick = en & reset & (presc_q == PRESC_MAX);
        end
    endgenerate

endmodule : tick_gen

// File: rtl/synch_updown_counter.sv
// Up/down counter over 0..MODULUS-1 with wrap or saturate, synchronous
// clamped load, terminal-count pulse and an integrated step prescaler.
module synch_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULUS  = 16,
    parameter int unsigned DIV_BITS = DEF_DIV_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    synch_updown_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MODULUS - 1);

    generate
        if (MODULUS < 2 || 64'(MODULUS) > (64'(1) << WIDTH)) begin : g_bad_modulus
            $error("synch_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    logic             tick_w;
    logic             at_term;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             tc_q;
    logic             tc_d;

    tick_gen #(
        .DIV_BITS (DIV_BITS)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (bus.en),
        .clr   (bus.load),
        .tick  (tick_w)
    );

    // Next count: load beats step beats hold; range ends compared explicitly.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        at_term = (bus.dir == DIR_UP) ? (count_q == CNT_MAX) : (count_q == '0);

        if (bus.load) begin
            count_d = (bus.load_val > CNT_MAX) ? CNT_MAX : bus.load_val;
        end else if (tick_w) begin
            tc_d = at_term;
            if (bus.dir == DIR_UP) begin
                if (at_term) begin
                    count_d = (bus.sat == MODE_SAT) ? count_q : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_term) begin
                    count_d = (bus.sat == MODE_SAT) ? count_q : CNT_MAX;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.count = count_q;
    assign bus.tc    = tc_q;
    assign bus.tick  = tick_w;

endmodule : synch_updown_counter

// File: tb/tb_synch_updown_counter.sv
// Drives two counter configurations (MOD10/DIV2 and MOD16/DIV0) with the same
// stimulus and compares each against its own arithmetic reference model.
module tb_synch_updown_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b1;
    logic       sat = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state, index 0 = MOD10/DIV2, index 1 = MOD16/DIV0.
    int m_cnt [2];
    int m_ph  [2];
    int m_tc  [2];
    int mod_v [2] = '{10, 16};
    int per_v [2] = '{4, 1};

    always #5 clk = ~clk;

    synch_updown_counter_if #(.WIDTH(4)) bus_a ();
    synch_updown_counter_if #(.WIDTH(4)) bus_b ();

    assign bus_a.en = en;   assign bus_b.en = en;
    assign bus_a.dir = dir; assign bus_b.dir = dir;
    assign bus_a.sat = sat; assign bus_b.sat = sat;
    assign bus_a.load = load; assign bus_b.load = load;
    assign bus_a.load_val = load_val; assign bus_b.load_val = load_val;

    synch_updown_counter #(.WIDTH(4), .MODULUS(10), .DIV_BITS(2)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    synch_updown_counter #(.WIDTH(4), .MODULUS(16), .DIV_BITS(0)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] obs_count(input int i);
        return (i == 0) ? 32'(bus_a.count) : 32'(bus_b.count);
    endfunction

    function automatic logic [31:0] obs_tc(input int i);
        return (i == 0) ? 32'(bus_a.tc) : 32'(bus_b.tc);
    endfunction

    function automatic logic [31:0] obs_tick(input int i);
        return (i == 0) ? 32'(bus_a.tick) : 32'(bus_b.tick);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0;
            m_ph[i]  = 0;
            m_tc[i]  = 0;
        end
    endfunction

    // One clock edge of the behavioural counter.
    function automatic void model_step(input int i, input logic e, input logic d,
                                       input logic s, input logic l, input int v,
                                       input logic t);
        int top;
        bit term;
        top = mod_v[i] - 1;
        m_tc[i] = 0;
        if (l) begin
            m_cnt[i] = (v > top) ? top : v;
            m_ph[i]  = 0;
        end else begin
            if (t) begin
                term     = d ? (m_cnt[i] == top) : (m_cnt[i] == 0);
                m_tc[i]  = term ? 1 : 0;
                if (!term)  m_cnt[i] = d ? m_cnt[i] + 1 : m_cnt[i] - 1;
                else if (!s) m_cnt[i] = d ? 0 : top;
            end
            if (e) m_ph[i] = (m_ph[i] + 1) % per_v[i];
        end
    endfunction

    task automatic run_cycle(input logic e, input logic d, input logic s,
                             input logic l, input logic [3:0] v);
        logic t [2];
        @(negedge clk);
        en = e; dir = d; sat = s; load = l; load_val = v;
        #1;
        for (int i = 0; i < 2; i++) begin
            t[i] = e && (m_ph[i] == per_v[i] - 1);
            check($sformatf("tick%0d", i), obs_tick(i), 32'(t[i]));
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, e, d, s, l, int'(v), t[i]);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("count%0d", i), obs_count(i), 32'(m_cnt[i]));
            check($sformatf("tc%0d", i), obs_tc(i), 32'(m_tc[i]));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; en = 1'b1; load = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_count%0d", i), obs_count(i), 32'd0);
            check($sformatf("rst_tc%0d", i), obs_tc(i), 32'd0);
            check($sformatf("rst_tick%0d", i), obs_tick(i), 32'd0);
        end
        model_reset();
        @(posedge clk);
        #1 en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        int tc_seen;
        model_reset();
        do_reset();

        // Up-count wrap at MOD10: one tc pulse on the 9->0 step.
        tc_seen = 0;
        for (int k = 0; k < 44; k++) begin
            run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
            tc_seen += int'(bus_a.tc);
        end
        check("wrap_tc_pulses", 32'(tc_seen), 32'd1);
        check("wrap_end_count", obs_count(0), 32'd1);

        // Saturated down-count from 0.
        run_cycle(1'b1, 1'b0, 1'b1, 1'b1, 4'd0);
        for (int k = 0; k < 12; k++) run_cycle(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);

        // Out-of-range load clamps.
        run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'd13);
        check("load_clamp", obs_count(0), 32'd9);
        for (int k = 0; k < 6; k++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        // Load coinciding with a tick.
        for (int k = 0; k < 4 && m_ph[0] != 3; k++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'd3);
        check("load_beats_tick", obs_count(0), 32'd3);

        // en dropped mid-period.
        for (int k = 0; k < 4 && m_ph[0] != 2; k++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 7; k++) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 6; k++) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        // Asynchronous reset between edges.
        run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'd6);
        @(posedge clk);
        #1 check("pre_async_count", obs_count(0), 32'd6);
        #1 reset = 1'b0;
        #1;
        check("async_count", obs_count(0), 32'd0);
        check("async_tc", obs_tc(0), 32'd0);
        check("async_count_b", obs_count(1), 32'd0);
        en = 1'b0; load = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Random mix of all controls.
        for (int k = 0; k < 400; k++) begin
            run_cycle($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                      $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
            if (k == 200) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_synch_updown_counter
